inst_fifo_dual: RTL and testbench

//  Instruction buffer between fetch and the dual-issue decode stage. Fetch pushes 0-2
//  {pc,inst} pairs per cycle. Decode sees the two oldest entries combinationally on

---
 rtl/inst_fifo_dual.sv | 95 +++++++++
 tb/tb_inst_fifo_dual.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/inst_fifo_dual.sv
// rtl/inst_fifo_dual.sv - dual-push/dual-pop instruction buffer between fetch and decode
module inst_fifo_dual #(
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       flush,
  input  logic                       in_en0,
  input  logic                       in_en1,
  input  logic [31:0]                in_pc0,
  input  logic [31:0]                in_inst0,
  input  logic [31:0]                in_pc1,
  input  logic [31:0]                in_inst1,
  input  logic                       issue0,
  input  logic                       issue1,
  output logic                       out_valid0,
  output logic                       out_valid1,
  output logic [31:0]                out_pc0,
  output logic [31:0]                out_inst0,
  output logic [31:0]                out_pc1,
  output logic [31:0]                out_inst1,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   pc_mem   [DEPTH];
  logic [31:0]   inst_mem [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [AW-1:0] head_next1;
  logic [AW-1:0] tail_next1;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic [1:0]    push_n;
  logic [1:0]    push_eff;
  logic [1:0]    pop_req;
  logic [1:0]    pop_n;
  logic          do_push;

  assign full       = (cnt > CW'(DEPTH - 2));
  assign empty      = (cnt == '0);
  assign count      = cnt;
  assign out_valid0 = (cnt >= CW'(1));
  assign out_valid1 = (cnt >= CW'(2));
  assign head_next1 = head + AW'(1);
  assign tail_next1 = tail + AW'(1);

  // Invalid slots read as zero so decode never sees stale words.
  assign out_pc0   = out_valid0 ? pc_mem[head]         : 32'h0;
  assign out_inst0 = out_valid0 ? inst_mem[head]       : 32'h0;
  assign out_pc1   = out_valid1 ? pc_mem[head_next1]   : 32'h0;
  assign out_inst1 = out_valid1 ? inst_mem[head_next1] : 32'h0;

  always_comb begin
    push_n   = {1'b0, in_en0} + {1'b0, in_en1};
    do_push  = (push_n != 2'd0) && !full;
    push_eff = do_push ? push_n : 2'd0;
    pop_req  = issue0 ? (issue1 ? 2'd2 : 2'd1) : 2'd0;
    pop_n    = (CW'(pop_req) > cnt) ? cnt[1:0] : pop_req;
    cnt_next = cnt + CW'(push_eff) - CW'(pop_n);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else if (flush) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      tail <= tail + AW'(push_eff);
      head <= head + AW'(pop_n);
      cnt  <= cnt_next;
    end
  end

  // Enabled fetch slots are compacted: the first enabled one lands at tail.
  always_ff @(posedge clk) begin
    if (!flush && do_push) begin
      pc_mem[tail]   <= in_en0 ? in_pc0   : in_pc1;
      inst_mem[tail] <= in_en0 ? in_inst0 : in_inst1;
      if (in_en0 && in_en1) begin
        pc_mem[tail_next1]   <= in_pc1;
        inst_mem[tail_next1] <= in_inst1;
      end
    end
  end

endmodule

// File: tb/tb_inst_fifo_dual.sv
// tb/tb_inst_fifo_dual.sv - directed self-checking bench for inst_fifo_dual
module tb_inst_fifo_dual;

  logic        clk = 1'b0;
  logic        resetn, flush, in_en0, in_en1, issue0, issue1;
  logic [31:0] in_pc0, in_inst0, in_pc1, in_inst1;
  logic        out_valid0, out_valid1, empty, full;
  logic [31:0] out_pc0, out_inst0, out_pc1, out_inst1;
  logic [4:0]  count;

  int tests_run = 0;
  int tests_failed = 0;
  logic [31:0] next_pc;
  logic [31:0] head_pc;

  always #5 clk = ~clk;

  inst_fifo_dual #(.DEPTH(16)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .in_en0(in_en0), .in_en1(in_en1),
    .in_pc0(in_pc0), .in_inst0(in_inst0), .in_pc1(in_pc1), .in_inst1(in_inst1),
    .issue0(issue0), .issue1(issue1),
    .out_valid0(out_valid0), .out_valid1(out_valid1),
    .out_pc0(out_pc0), .out_inst0(out_inst0), .out_pc1(out_pc1), .out_inst1(out_inst1),
    .empty(empty), .full(full), .count(count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    flush = 0; in_en0 = 0; in_en1 = 0; issue0 = 0; issue1 = 0;
    in_pc0 = 0; in_inst0 = 0; in_pc1 = 0; in_inst1 = 0;
  endtask

  // Drive one cycle of stimulus at the falling edge, return 1ns after the rising edge.
  task automatic step(input logic e0, input logic [31:0] p0, input logic [31:0] i0,
                      input logic e1, input logic [31:0] p1, input logic [31:0] i1,
                      input logic is0, input logic is1, input logic fl);
    @(negedge clk);
    in_en0 = e0; in_pc0 = p0; in_inst0 = i0;
    in_en1 = e1; in_pc1 = p1; in_inst1 = i1;
    issue0 = is0; issue1 = is1; flush = fl;
    @(posedge clk);
    #1 idle();
  endtask

  initial begin
    idle();
    resetn = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_valid0", 32'(out_valid0), 32'd0);
    chk("rst_valid1", 32'(out_valid1), 32'd0);
    chk("rst_pc0", out_pc0, 32'h0);
    chk("rst_inst1", out_inst1, 32'h0);
    @(negedge clk);
    resetn = 1;

    // 1: dual push, no bypass before the edge
    @(negedge clk);
    in_en0 = 1; in_pc0 = 32'hBFC00000; in_inst0 = 32'h24010001;
    in_en1 = 1; in_pc1 = 32'hBFC00004; in_inst1 = 32'h24020002;
    #1;
    chk("t1_nobypass_valid0", 32'(out_valid0), 32'd0);
    chk("t1_nobypass_pc0", out_pc0, 32'h0);
    @(posedge clk);
    #1 idle();
    chk("t1_count", 32'(count), 32'd2);
    chk("t1_valid0", 32'(out_valid0), 32'd1);
    chk("t1_valid1", 32'(out_valid1), 32'd1);
    chk("t1_pc0", out_pc0, 32'hBFC00000);
    chk("t1_inst0", out_inst0, 32'h24010001);
    chk("t1_pc1", out_pc1, 32'hBFC00004);
    chk("t1_inst1", out_inst1, 32'h24020002);
    chk("t1_empty", 32'(empty), 32'd0);

    // 2: fill to 15 with single pushes, then a dropped dual push
    for (int i = 0; i < 12; i++)
      step(1, 32'h1000 + 32'(i) * 4, 32'hA000 + 32'(i), 0, 0, 0, 0, 0, 0);
    chk("t2_count14", 32'(count), 32'd14);
    chk("t2_full_at14", 32'(full), 32'd0);
    step(1, 32'h1030, 32'hA00C, 0, 0, 0, 0, 0, 0);
    chk("t2_count15", 32'(count), 32'd15);
    chk("t2_full", 32'(full), 32'd1);
    step(1, 32'hDEAD0000, 32'h1, 1, 32'hDEAD0004, 32'h2, 0, 0, 0);
    chk("t2_drop_count", 32'(count), 32'd15);
    chk("t2_drop_pc0", out_pc0, 32'hBFC00000);
    chk("t2_drop_pc1", out_pc1, 32'hBFC00004);
    chk("t2_drop_full", 32'(full), 32'd1);

    // 3: drain to 1, then a dual issue pops only one
    for (int i = 0; i < 7; i++) step(0, 0, 0, 0, 0, 0, 1, 1, 0);
    chk("t3_count1", 32'(count), 32'd1);
    chk("t3_last_pc0", out_pc0, 32'h1030);
    chk("t3_valid1", 32'(out_valid1), 32'd0);
    chk("t3_pc1_zero", out_pc1, 32'h0);
    step(0, 0, 0, 0, 0, 0, 1, 1, 0);
    chk("t3_count0", 32'(count), 32'd0);
    chk("t3_empty", 32'(empty), 32'd1);
    chk("t3_inst0", out_inst0, 32'h0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    chk("t3_issue1_only", 32'(count), 32'd0);

    // 4: count=5 steady state with push2+pop2 across the pointer wrap (head starts at 15)
    next_pc = 32'h2000;
    head_pc = 32'h2000;
    step(1, next_pc, ~next_pc, 1, next_pc + 4, ~(next_pc + 4), 0, 0, 0);
    next_pc += 8;
    step(1, next_pc, ~next_pc, 1, next_pc + 4, ~(next_pc + 4), 0, 0, 0);
    next_pc += 8;
    step(1, next_pc, ~next_pc, 0, 0, 0, 0, 0, 0);
    next_pc += 4;
    chk("t4_count5", 32'(count), 32'd5);
    for (int i = 0; i < 20; i++) begin
      chk("t4_pc0", out_pc0, head_pc);
      chk("t4_pc1", out_pc1, head_pc + 4);
      chk("t4_inst0", out_inst0, ~head_pc);
      step(1, next_pc, ~next_pc, 1, next_pc + 4, ~(next_pc + 4), 1, 1, 0);
      next_pc += 8;
      head_pc += 8;
      chk("t4_count", 32'(count), 32'd5);
    end
    chk("t4_final_pc0", out_pc0, head_pc);

    // 5: flush beats a same-cycle push and pop
    step(1, next_pc, ~next_pc, 1, next_pc + 4, ~(next_pc + 4), 0, 0, 0);
    step(1, next_pc + 8, ~(next_pc + 8), 0, 0, 0, 0, 0, 0);
    chk("t5_count8", 32'(count), 32'd8);
    step(1, 32'hCAFE0000, 32'hCAFE0001, 0, 0, 0, 1, 0, 1);
    chk("t5_count", 32'(count), 32'd0);
    chk("t5_empty", 32'(empty), 32'd1);
    chk("t5_valid0", 32'(out_valid0), 32'd0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("t5_no_ghost_pc0", out_pc0, 32'h0);
    chk("t5_no_ghost_count", 32'(count), 32'd0);

    // 6: in_en1-only push at tail=3, then async reset with no clock edge
    step(1, 32'h4000, 32'h1, 1, 32'h4004, 32'h2, 0, 0, 0);
    step(1, 32'h4008, 32'h3, 0, 0, 0, 0, 0, 0);
    chk("t6_count3", 32'(count), 32'd3);
    step(0, 32'hFFFF0000, 32'hFFFF, 1, 32'h3000, 32'h00000000, 0, 0, 0);
    chk("t6_count4", 32'(count), 32'd4);
    step(0, 0, 0, 0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0, 0);
    chk("t6_count1", 32'(count), 32'd1);
    chk("t6_pc_idx3", out_pc0, 32'h3000);
    chk("t6_inst_idx3", out_inst0, 32'h0);
    chk("t6_valid0", 32'(out_valid0), 32'd1);
    @(negedge clk);
    #2 resetn = 0;
    #1;
    chk("t6_async_empty", 32'(empty), 32'd1);
    chk("t6_async_count", 32'(count), 32'd0);
    chk("t6_async_valid0", 32'(out_valid0), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
